// File: rtl/snake_gfx_pkg.sv
// rtl/snake_gfx_pkg.sv - shared object codes, RGB565 palette and grid/tile geometry for the snake renderer
package snake_gfx_pkg;

  typedef enum logic [2:0] {
    blank      = 3'd0,
    snake_head = 3'd1,
    snake_body = 3'd2,
    apple_c    = 3'd3,
    border_c   = 3'd4
  } obj_code_t;

  localparam logic [15:0] COLOR_BLANK   = 16'h0000;
  localparam logic [15:0] COLOR_HEAD    = 16'h07E0;
  localparam logic [15:0] COLOR_BODY    = 16'h03E0;
  localparam logic [15:0] COLOR_APPLE   = 16'hF800;
  localparam logic [15:0] COLOR_BORDER  = 16'hFFFF;
  localparam logic [15:0] COLOR_ERROR   = 16'hF81F;
  localparam logic [15:0] OUTLINE_COLOR = 16'h2104;

  localparam int DEF_GRID_W = 16;
  localparam int DEF_GRID_H = 12;
  localparam int DEF_TILE_W = 20;
  localparam int DEF_TILE_H = 20;

  function automatic logic [15:0] code_color(input obj_code_t code);
    case (code)
      blank:      code_color = COLOR_BLANK;
      snake_head: code_color = COLOR_HEAD;
      snake_body: code_color = COLOR_BODY;
      apple_c:    code_color = COLOR_APPLE;
      border_c:   code_color = COLOR_BORDER;
      default:    code_color = COLOR_ERROR;
    endcase
  endfunction

endpackage

// File: rtl/tile_pixel_counter.sv
// rtl/tile_pixel_counter.sv - row-major col/row walker over one tile, exposing the next position and last-pixel flag
module tile_pixel_counter #(
  parameter int TILE_W = 20,
  parameter int TILE_H = 20,
  localparam int CW = $clog2(TILE_W),
  localparam int RW = $clog2(TILE_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_advance,
  output logic [CW-1:0] o_nxt_col,
  output logic [RW-1:0] o_nxt_row,
  output logic          o_last
);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_col_last;
  logic          w_row_last;

  assign w_col_last = (r_col == CW'(TILE_W - 1));
  assign w_row_last = (r_row == RW'(TILE_H - 1));
  assign o_last     = w_col_last && w_row_last;

  assign o_nxt_col = w_col_last ? '0 : r_col + 1'b1;
  assign o_nxt_row = w_col_last ? (w_row_last ? '0 : r_row + 1'b1) : r_row;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_advance) begin
      r_col <= o_nxt_col;
      r_row <= o_nxt_row;
    end
  end

endmodule

// File: rtl/tile_painter.sv
// rtl/tile_painter.sv - captures a changed grid cell and streams its tile pixels to the display writer
// Optional macro TILE_OUTLINE_EN: outline col 0 / row 0 of non-blank tiles in OUTLINE_COLOR.
module tile_painter
  import snake_gfx_pkg::*;
#(
  parameter int TILE_W = DEF_TILE_W,
  parameter int TILE_H = DEF_TILE_H,
  parameter int GRID_W = DEF_GRID_W,
  parameter int GRID_H = DEF_GRID_H,
  localparam int CW = $clog2(TILE_W),
  localparam int RW = $clog2(TILE_H)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  obj_code,
  input  logic [3:0]  x,
  input  logic [3:0]  y,
  input  logic        diff,
  output logic        scan_en,
  output logic        px_valid,
  input  logic        px_ready,
  output logic [8:0]  px_x,
  output logic [8:0]  px_y,
  output logic [15:0] px_color,
  output logic        busy,
  output logic [7:0]  tiles_painted
);

  typedef enum logic {IDLE = 1'b0, PAINT = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  obj_code_t       r_code;
  obj_code_t       w_in_code;
  logic [8:0]      r_base_x;
  logic [8:0]      r_base_y;
  logic [8:0]      r_px_x;
  logic [8:0]      r_px_y;
  logic [15:0]     r_px_color;
  logic [7:0]      r_tiles;
  logic [8:0]      w_base_x;
  logic [8:0]      w_base_y;
  logic [15:0]     w_cap_color;
  logic [15:0]     w_nxt_color;
  logic            w_in_range;
  logic            w_capture;
  logic            w_xfer;
  logic            w_done;
  logic            w_last;
  logic [CW-1:0]   w_nxt_col;
  logic [RW-1:0]   w_nxt_row;

  assign w_in_code  = obj_code_t'(obj_code);
  assign w_base_x   = 9'(x) * 9'(TILE_W);
  assign w_base_y   = 9'(y) * 9'(TILE_H);
  assign w_in_range = (32'(x) < 32'(GRID_W)) && (32'(y) < 32'(GRID_H));

`ifdef TILE_OUTLINE_EN
  // The capture beat is always col 0 / row 0, so a non-blank tile starts on the outline.
  assign w_cap_color = (w_in_code != blank) ? OUTLINE_COLOR : code_color(w_in_code);
  assign w_nxt_color = (r_code != blank && (w_nxt_col == '0 || w_nxt_row == '0))
                       ? OUTLINE_COLOR : code_color(r_code);
`else
  assign w_cap_color = code_color(w_in_code);
  assign w_nxt_color = code_color(r_code);
`endif

  tile_pixel_counter #(
    .TILE_W (TILE_W),
    .TILE_H (TILE_H)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_capture),
    .i_advance (w_xfer),
    .o_nxt_col (w_nxt_col),
    .o_nxt_row (w_nxt_row),
    .o_last    (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    scan_en     = 1'b0;
    busy        = 1'b0;
    px_valid    = 1'b0;
    w_capture   = 1'b0;
    w_xfer      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        scan_en = 1'b1;
        if (diff && w_in_range) begin
          w_capture   = 1'b1;
          w_state_nxt = PAINT;
        end
      end
      PAINT: begin
        busy     = 1'b1;
        px_valid = 1'b1;
        if (px_ready) begin
          w_xfer = 1'b1;
          if (w_last) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pixel outputs are preloaded with the next beat on each transfer, so they only move on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_code     <= blank;
      r_base_x   <= '0;
      r_base_y   <= '0;
      r_px_x     <= '0;
      r_px_y     <= '0;
      r_px_color <= '0;
      r_tiles    <= '0;
    end else if (w_capture) begin
      r_code     <= w_in_code;
      r_base_x   <= w_base_x;
      r_base_y   <= w_base_y;
      r_px_x     <= w_base_x;
      r_px_y     <= w_base_y;
      r_px_color <= w_cap_color;
    end else if (w_xfer) begin
      if (w_done) begin
        r_tiles <= r_tiles + 8'd1;
      end else begin
        r_px_x     <= r_base_x + 9'(w_nxt_col);
        r_px_y     <= r_base_y + 9'(w_nxt_row);
        r_px_color <= w_nxt_color;
      end
    end
  end

  assign px_x          = r_px_x;
  assign px_y          = r_px_y;
  assign px_color      = r_px_color;
  assign tiles_painted = r_tiles;

endmodule

// File: tb/tb_tile_painter.sv
// tb/tb_tile_painter.sv - scoreboard bench for tile_painter: expected beats queued at stimulus, checked by a monitor
module tb_tile_painter;

  typedef struct {
    int          bx;
    int          by;
    logic [15:0] color;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  obj_code;
  logic [3:0]  x;
  logic [3:0]  y;
  logic        diff;
  logic        scan_en;
  logic        px_valid;
  logic        px_ready;
  logic [8:0]  px_x;
  logic [8:0]  px_y;
  logic [15:0] px_color;
  logic        busy;
  logic [7:0]  tiles_painted;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    exp_tiles = 0;

  always #5 clk = ~clk;

  tile_painter dut (
    .clk           (clk),
    .rst           (rst),
    .obj_code      (obj_code),
    .x             (x),
    .y             (y),
    .diff          (diff),
    .scan_en       (scan_en),
    .px_valid      (px_valid),
    .px_ready      (px_ready),
    .px_x          (px_x),
    .px_y          (px_y),
    .px_color      (px_color),
    .busy          (busy),
    .tiles_painted (tiles_painted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_color(input int code, input int c, input int r);
    logic [15:0] v;
    case (code)
      0:       v = 16'h0000;
      1:       v = 16'h07E0;
      2:       v = 16'h03E0;
      3:       v = 16'hF800;
      4:       v = 16'hFFFF;
      default: v = 16'hF81F;
    endcase
`ifdef TILE_OUTLINE_EN
    if (code != 0 && (c == 0 || r == 0)) v = 16'h2104;
`endif
    return v;
  endfunction

  // Monitor: compares presented beats against the queue head; pops only on acceptance.
  always @(negedge clk) begin
    if (!rst && px_valid) begin
      chk("scan_en_low_in_paint", 32'(scan_en), 32'd0);
      chk("busy_in_paint", 32'(busy), 32'd1);
      if (exp_q.size() == 0) begin
        if (px_ready) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got (%0d,%0d) %0h, expected no beat", px_x, px_y, px_color);
        end
      end else begin
        chk("px_x", 32'(px_x), 32'(exp_q[0].bx));
        chk("px_y", 32'(px_y), 32'(exp_q[0].by));
        chk("px_color", 32'(px_color), 32'(exp_q[0].color));
        if (px_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic paint(input int tx, input int ty, input int tc,
                       input bit rnd, input bit hold, input int abort_at);
    int cycles = 0;
    int total;
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 20; c++) begin
        beat_t b;
        b.bx = tx * 20 + c;
        b.by = ty * 20 + r;
        b.color = exp_color(tc, c, r);
        exp_q.push_back(b);
      end
    total = exp_q.size();
    @(posedge clk); #1;
    diff = 1'b1; x = 4'(tx); y = 4'(ty); obj_code = 3'(tc);
    @(posedge clk); #1;
    diff = 1'b0;
    @(negedge clk);
    chk("first_beat_latency", 32'(px_valid), 32'd1);
    forever begin
      @(posedge clk); #1;
      cycles++;
      if (exp_q.size() == 0) break;
      if (abort_at != 0 && total - exp_q.size() == abort_at) begin
        rst = 1'b1; px_ready = 1'b0; exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0; px_ready = 1'b1; exp_tiles = 0;
        @(negedge clk);
        chk("abort_px_valid", 32'(px_valid), 32'd0);
        chk("abort_scan_en", 32'(scan_en), 32'd1);
        chk("abort_tiles", 32'(tiles_painted), 32'd0);
        return;
      end
      if (cycles > 5000) begin
        n_checks++;
        n_fail++;
        $display("FAIL paint_timeout: got %0d beats left, expected 0", exp_q.size());
        exp_q.delete();
        break;
      end
      if (rnd) px_ready = 1'($urandom_range(0, 1));
      if (hold) begin diff = 1'b1; x = 4'd5; y = 4'd5; obj_code = 3'd4; end
    end
    diff = 1'b0;
    px_ready = 1'b1;
    exp_tiles++;
    if (!rnd) chk("throughput_cycles", 32'(cycles), 32'd400);
    @(negedge clk);
    chk("done_px_valid", 32'(px_valid), 32'd0);
    chk("done_scan_en", 32'(scan_en), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("tiles_painted", 32'(tiles_painted), 32'(exp_tiles & 255));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst = 1'b1; diff = 1'b0; x = '0; y = '0; obj_code = '0; px_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_scan_en", 32'(scan_en), 32'd1);
    chk("rst_px_valid", 32'(px_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_px_x", 32'(px_x), 32'd0);
    chk("rst_px_y", 32'(px_y), 32'd0);
    chk("rst_px_color", 32'(px_color), 32'd0);
    chk("rst_tiles", 32'(tiles_painted), 32'd0);

    paint(3, 2, 1, 1'b0, 1'b0, 0);
    paint(3, 2, 1, 1'b1, 1'b1, 0);
    paint(15, 11, 4, 1'b0, 1'b0, 0);

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (scan_en !== 1'b1 || px_valid !== 1'b0) bad++;
    end
    chk("idle_violations", 32'(bad), 32'd0);
    chk("idle_tiles", 32'(tiles_painted), 32'(exp_tiles));

    @(posedge clk); #1;
    diff = 1'b1; x = 4'd2; y = 4'd12; obj_code = 3'd1;
    @(posedge clk); #1;
    diff = 1'b0;
    @(negedge clk);
    chk("out_of_range_px_valid", 32'(px_valid), 32'd0);
    chk("out_of_range_scan_en", 32'(scan_en), 32'd1);

    paint(9, 4, 2, 1'b0, 1'b0, 100);
    paint(0, 0, 2, 1'b0, 1'b0, 0);
    paint(7, 3, 6, 1'b1, 1'b0, 0);
    paint(1, 1, 3, 1'b0, 1'b0, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
